// File: rtl/control_sequencer.sv
// control_sequencer: hardwired Moore control unit for fetch/decode/execute of the datapath
// Ports: i_clock/i_clear_n clock and async active-low reset; i_ir instruction from datapath;
//   i_stop halt request sampled at instruction boundary; o_rin/o_rout one-hot register
//   load/drive; o_* single-bit datapath strobes; o_alu_op ALU select; o_run busy; o_tstate debug step.
module control_sequencer #(
  parameter int NREGS = 16,
  parameter int IRW = 32,
  parameter int OPW = 5
) (
  input  logic             i_clock,
  input  logic             i_clear_n,
  input  logic [IRW-1:0]   i_ir,
  input  logic             i_stop,
  output logic [NREGS-1:0] o_rin,
  output logic [NREGS-1:0] o_rout,
  output logic             o_baout,
  output logic             o_cout,
  output logic             o_pcout,
  output logic             o_pcin,
  output logic             o_incpc,
  output logic             o_marin,
  output logic             o_zin,
  output logic             o_zloout,
  output logic             o_yin,
  output logic             o_irin,
  output logic             o_mdrin,
  output logic             o_mdrout,
  output logic             o_read,
  output logic             o_write,
  output logic [OPW-1:0]   o_alu_op,
  output logic             o_run,
  output logic [3:0]       o_tstate
);
  localparam int RW = $clog2(NREGS);
  localparam logic [OPW-1:0] OP_LD = OPW'(0), OP_LDI = OPW'(1), OP_ST = OPW'(2), OP_ADD = OPW'(3),
    OP_SUB = OPW'(4), OP_AND = OPW'(5), OP_OR = OPW'(6), OP_ADDI = OPW'(12), OP_ANDI = OPW'(13),
    OP_ORI = OPW'(14), OP_HALT = OPW'(27);
  // Encoding doubles as the debug step number.
  typedef enum logic [3:0] {
    S_RST = 4'd0, S_T0 = 4'd1, S_T1 = 4'd2, S_T2 = 4'd3, S_T3 = 4'd4,
    S_T4 = 4'd5, S_T5 = 4'd6, S_T6 = 4'd7, S_T7 = 4'd8, S_HALT = 4'd15
  } state_t;
  state_t r_state, w_next, w_done;
  logic [OPW-1:0] w_op;
  logic [RW-1:0] w_ra, w_rb, w_rc;
  logic [NREGS-1:0] w_ra1h, w_rb1h, w_rc1h;
  logic w_alu, w_imm, w_ld, w_ldi, w_st, w_mem, w_halt, w_exec, w_base0, w_unused;
  assign w_op = i_ir[IRW-1 -: OPW];
  assign w_ra = i_ir[IRW-OPW-1 -: RW];
  assign w_rb = i_ir[IRW-OPW-RW-1 -: RW];
  assign w_rc = i_ir[IRW-OPW-2*RW-1 -: RW];
  assign w_unused = ^i_ir[IRW-OPW-3*RW-1:0];
  assign w_ra1h = NREGS'(1) << w_ra;
  assign w_rb1h = NREGS'(1) << w_rb;
  assign w_rc1h = NREGS'(1) << w_rc;
  assign w_alu = w_op inside {OP_ADD, OP_SUB, OP_AND, OP_OR};
  assign w_imm = w_op inside {OP_ADDI, OP_ANDI, OP_ORI};
  assign w_ld = w_op == OP_LD;
  assign w_ldi = w_op == OP_LDI;
  assign w_st = w_op == OP_ST;
  assign w_mem = w_ld | w_ldi | w_st;
  assign w_halt = w_op == OP_HALT;
  assign w_exec = w_alu | w_imm | w_mem;
  // R0 as an address base reads as constant zero, so BAout replaces its bus drive.
  assign w_base0 = w_mem && w_rb == '0;
  // Stop is only honoured on the edge that ends an instruction.
  assign w_done = i_stop ? S_HALT : S_T0;
  assign o_tstate = r_state;
  assign o_run = r_state != S_RST && r_state != S_HALT;
  always_ff @(posedge i_clock or negedge i_clear_n)
    if (!i_clear_n) r_state <= S_RST;
    else r_state <= w_next;
  always_comb begin
    w_next = S_HALT;
    o_rin = '0;
    o_rout = '0;
    o_baout = 1'b0;
    o_cout = 1'b0;
    o_pcout = 1'b0;
    o_pcin = 1'b0;
    o_incpc = 1'b0;
    o_marin = 1'b0;
    o_zin = 1'b0;
    o_zloout = 1'b0;
    o_yin = 1'b0;
    o_irin = 1'b0;
    o_mdrin = 1'b0;
    o_mdrout = 1'b0;
    o_read = 1'b0;
    o_write = 1'b0;
    o_alu_op = '0;
    case (r_state)
      S_RST: w_next = S_T0;
      S_T0: begin
        o_pcout = 1'b1;
        o_marin = 1'b1;
        o_incpc = 1'b1;
        o_zin = 1'b1;
        w_next = S_T1;
      end
      S_T1: begin
        o_zloout = 1'b1;
        o_pcin = 1'b1;
        o_read = 1'b1;
        o_mdrin = 1'b1;
        w_next = S_T2;
      end
      S_T2: begin
        o_mdrout = 1'b1;
        o_irin = 1'b1;
        w_next = w_halt ? S_HALT : w_exec ? S_T3 : w_done;
      end
      S_T3: begin
        o_yin = 1'b1;
        o_baout = w_base0;
        o_rout = w_base0 ? '0 : w_rb1h;
        w_next = S_T4;
      end
      S_T4: begin
        o_zin = 1'b1;
        o_cout = !w_alu;
        o_rout = w_alu ? w_rc1h : '0;
        o_alu_op = w_mem ? OP_ADD : w_op;
        w_next = S_T5;
      end
      S_T5: begin
        o_zloout = 1'b1;
        o_marin = w_ld | w_st;
        o_rin = (w_alu | w_imm | w_ldi) ? w_ra1h : '0;
        w_next = (w_ld | w_st) ? S_T6 : w_done;
      end
      S_T6: begin
        o_mdrin = 1'b1;
        o_read = w_ld;
        o_rout = w_st ? w_ra1h : '0;
        w_next = S_T7;
      end
      S_T7: begin
        o_mdrout = w_ld;
        o_rin = w_ld ? w_ra1h : '0;
        o_write = w_st;
        w_next = w_done;
      end
      default: w_next = S_HALT;
    endcase
  end
endmodule
